// File: rtl/stage_seq_pkg.sv
// rtl/stage_seq_pkg.sv - shared types, defaults and index helper for stage_sequencer
package stage_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam int CNT_W_DEFAULT = 32;
    localparam int MAX_STAGES    = 32;

    // Lowest enabled index in [from, num), or num when none is enabled.
    function automatic int next_en_idx(input logic [MAX_STAGES-1:0] mask,
                                       input int from,
                                       input int num);
        int r;
        r = num;
        for (int i = MAX_STAGES - 1; i >= 0; i--) begin
            if (i >= from && i < num && mask[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stage_cycle_counter.sv
// rtl/stage_cycle_counter.sv - saturating cycle counter with clear and enable
module stage_cycle_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - in-order child stage sequencer with ap_ctrl_chain host side
// Optional profiling counters under `STAGE_PROFILE_EN.
module stage_sequencer
    import stage_seq_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              ap_start,
    input  logic [NUM_STAGES-1:0]             stage_en,
    input  logic                              ap_continue,
    output logic                              ap_ready,
    output logic                              ap_done,
    output logic                              ap_idle,
    output logic [NUM_STAGES-1:0]             stage_start,
    input  logic [NUM_STAGES-1:0]             stage_ready,
    input  logic [NUM_STAGES-1:0]             stage_done,
    output logic [$clog2(NUM_STAGES):0]       cur_stage,
    output logic [NUM_STAGES*CNT_W-1:0]       stage_cycles,
    output logic [CNT_W-1:0]                  total_cycles
);

    localparam int IDX_W = $clog2(NUM_STAGES) + 1;

    seq_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_STAGES-1:0]  en_q, en_d;
    logic                   accepted_q, accepted_d;
    logic [NUM_STAGES-1:0]  stage_start_q, stage_start_d;
    logic                   ap_done_q, ap_done_d;
    logic                   ap_idle_q, ap_idle_d;
    logic [IDX_W-1:0]       cur_stage_q, cur_stage_d;
    logic                   accept;
    logic [NUM_STAGES-1:0]  sel;
    int                     nxt;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        en_d       = en_q;
        accepted_d = accepted_q;
        accept     = 1'b0;
        nxt        = NUM_STAGES;
        sel        = NUM_STAGES'(1) << idx_q;
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    accept     = 1'b1;
                    en_d       = stage_en;
                    accepted_d = 1'b0;
                    nxt        = next_en_idx(MAX_STAGES'(stage_en), 0, NUM_STAGES);
                    idx_d      = IDX_W'(nxt);
                    state_d    = (nxt == NUM_STAGES) ? DONE : RUN;
                end
            end
            RUN: begin
                if (|(stage_ready & sel)) begin
                    accepted_d = 1'b1;
                end
                // Done implies ready, so completion does not wait for accepted.
                if (|(stage_done & sel)) begin
                    nxt        = next_en_idx(MAX_STAGES'(en_q), int'(idx_q) + 1, NUM_STAGES);
                    idx_d      = IDX_W'(nxt);
                    accepted_d = 1'b0;
                    if (nxt == NUM_STAGES) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (ap_continue) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        stage_start_d = (state_d == RUN && !accepted_d) ? (NUM_STAGES'(1) << idx_d) : '0;
        ap_done_d     = (state_d == DONE);
        ap_idle_d     = (state_d == IDLE);
        cur_stage_d   = (state_d == RUN) ? idx_d : IDX_W'(NUM_STAGES);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= IDX_W'(NUM_STAGES);
            en_q          <= '0;
            accepted_q    <= 1'b0;
            stage_start_q <= '0;
            ap_done_q     <= 1'b0;
            ap_idle_q     <= 1'b1;
            cur_stage_q   <= IDX_W'(NUM_STAGES);
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            en_q          <= en_d;
            accepted_q    <= accepted_d;
            stage_start_q <= stage_start_d;
            ap_done_q     <= ap_done_d;
            ap_idle_q     <= ap_idle_d;
            cur_stage_q   <= cur_stage_d;
        end
    end

    assign ap_ready    = accept;
    assign ap_done     = ap_done_q;
    assign ap_idle     = ap_idle_q;
    assign stage_start = stage_start_q;
    assign cur_stage   = cur_stage_q;

`ifdef STAGE_PROFILE_EN
    logic [NUM_STAGES:0] cnt_en;
    logic [CNT_W-1:0]    cnt [NUM_STAGES+1];

    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            cnt_en[i] = (state_q == RUN) && (idx_q == IDX_W'(i));
        end
        cnt_en[NUM_STAGES] = (state_q == RUN);
    end

    for (genvar g = 0; g <= NUM_STAGES; g++) begin : g_cnt
        stage_cycle_counter #(.W(CNT_W)) u_cnt (
            .clock (clock),
            .reset (reset),
            .clr   (accept),
            .en    (cnt_en[g]),
            .count (cnt[g])
        );
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_out
        assign stage_cycles[g*CNT_W +: CNT_W] = cnt[g];
    end
    assign total_cycles = cnt[NUM_STAGES];
`else
    assign stage_cycles = '0;
    assign total_cycles = '0;
`endif

endmodule
